commit_checker: RTL and testbench

//  Lock-step retirement checker for the isa-sim core. Takes the expected commit stream
//  (pc, inst, rd writeback, pc redirect) from a reference model into a FIFO. Pops and

---
 rtl/commit_checker.sv | 169 ++++++++++++++++
 tb/tb_commit_checker.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/commit_checker.sv
// Lock-step retirement checker: buffers reference-model commit records in a FIFO and
// compares the head against each DUT retirement, reporting per-field mismatches.
module commit_checker #(
  parameter int unsigned Depth     = 8,
  parameter bit          StopOnErr = 1'b1
) (
  input  logic                     clk_i,
  input  logic                     reset_ni,
  input  logic                     clear_i,
  input  logic                     exp_valid_i,
  output logic                     exp_ready_o,
  input  logic [31:0]              exp_pc_i,
  input  logic [31:0]              exp_inst_i,
  input  logic                     exp_rdv_i,
  input  logic [4:0]               exp_rd_i,
  input  logic [31:0]              exp_rd_data_i,
  input  logic                     exp_pcv_i,
  input  logic [31:0]              exp_pc_x_i,
  input  logic                     ret_valid_i,
  input  logic [31:0]              ret_pc_i,
  input  logic [31:0]              ret_inst_i,
  input  logic                     ret_rdv_i,
  input  logic [4:0]               ret_rd_i,
  input  logic [31:0]              ret_rd_data_i,
  input  logic                     ret_pcv_i,
  input  logic [31:0]              ret_pc_x_i,
  output logic                     mismatch_o,
  output logic [3:0]               mismatch_code_o,
  output logic [31:0]              mismatch_pc_o,
  output logic                     underflow_o,
  output logic                     halted_o,
  output logic [$clog2(Depth):0]   level_o,
  output logic [31:0]              retire_count_o,
  output logic [15:0]              error_count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned LvlW = PtrW + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        rdv;
    logic [4:0]  rd;
    logic [31:0] rd_data;
    logic        pcv;
    logic [31:0] pc_x;
  } rec_t;

  typedef enum logic [0:0] {StRun, StHalt} state_e;

  state_e          state_q, state_d;
  rec_t            mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0] level_q, level_d;
  logic            mismatch_q, mismatch_d;
  logic [3:0]      code_q, code_d;
  logic [31:0]     mis_pc_q, mis_pc_d;
  logic            underflow_q, underflow_d;
  logic [31:0]     retire_q, retire_d;
  logic [15:0]     error_q, error_d;

  logic full, empty, run, push, pop, under, mis, err_event;
  rec_t head;
  logic [3:0] code;

  assign full        = (level_q == LvlW'(Depth));
  assign empty       = (level_q == '0);
  assign run         = (state_q == StRun);
  assign exp_ready_o = !full && run;
  assign push        = exp_valid_i && exp_ready_o;
  assign pop         = ret_valid_i && !empty && run;
  assign under       = ret_valid_i && empty && run;
  assign head        = mem_q[rd_ptr_q];

  always_comb begin
    code    = '0;
    code[0] = (ret_pc_i != head.pc);
    code[1] = (ret_inst_i != head.inst);
    // Writes to x0 are architecturally discarded, so their data is not compared.
    code[2] = (ret_rdv_i != head.rdv) ||
              (ret_rdv_i && head.rdv &&
               ((ret_rd_i != head.rd) ||
                ((head.rd != 5'd0) && (ret_rd_data_i != head.rd_data))));
    code[3] = (ret_pcv_i != head.pcv) || (ret_pcv_i && head.pcv && (ret_pc_x_i != head.pc_x));
  end

  assign mis       = pop && (code != 4'd0);
  assign err_event = mis || under;

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    mismatch_d  = 1'b0;
    underflow_d = under;
    code_d      = code_q;
    mis_pc_d    = mis_pc_q;
    retire_d    = retire_q;
    error_d     = error_q;

    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    unique case ({push, pop})
      2'b10:   level_d = level_q + LvlW'(1);
      2'b01:   level_d = level_q - LvlW'(1);
      default: level_d = level_q;
    endcase

    if (mis) begin
      mismatch_d = 1'b1;
      code_d     = code;
      mis_pc_d   = ret_pc_i;
    end else if (under && StopOnErr) begin
      mismatch_d = 1'b1;
      code_d     = 4'hF;
      mis_pc_d   = ret_pc_i;
    end

    if (pop && (retire_q != '1))      retire_d = retire_q + 32'd1;
    if (err_event && (error_q != '1)) error_d  = error_q + 16'd1;
    if (err_event && StopOnErr)       state_d  = StHalt;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni || clear_i) begin
      state_q     <= StRun;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      mismatch_q  <= 1'b0;
      code_q      <= '0;
      mis_pc_q    <= '0;
      underflow_q <= 1'b0;
      retire_q    <= '0;
      error_q     <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      mismatch_q  <= mismatch_d;
      code_q      <= code_d;
      mis_pc_q    <= mis_pc_d;
      underflow_q <= underflow_d;
      retire_q    <= retire_d;
      error_q     <= error_d;
    end
  end

  // Storage needs no reset: occupancy is tracked by level_q alone.
  always_ff @(posedge clk_i) begin
    if (push && reset_ni && !clear_i) begin
      mem_q[wr_ptr_q] <= '{pc: exp_pc_i, inst: exp_inst_i, rdv: exp_rdv_i, rd: exp_rd_i,
                           rd_data: exp_rd_data_i, pcv: exp_pcv_i, pc_x: exp_pc_x_i};
    end
  end

  assign mismatch_o      = mismatch_q;
  assign mismatch_code_o = code_q;
  assign mismatch_pc_o   = mis_pc_q;
  assign underflow_o     = underflow_q;
  assign halted_o        = (state_q == StHalt);
  assign level_o         = level_q;
  assign retire_count_o  = retire_q;
  assign error_count_o   = error_q;

endmodule

// File: tb/tb_commit_checker.sv
// Directed bench for commit_checker: a halting instance and a non-halting instance share
// the same stimulus; each step checks the instance it targets.
module tb_commit_checker;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        rdv;
    logic [4:0]  rd;
    logic [31:0] rd_data;
    logic        pcv;
    logic [31:0] pc_x;
  } rec_t;

  logic clk = 1'b0;
  logic reset_n, clear, exp_valid, ret_valid;
  rec_t e, r;

  logic        s_ready, s_mis, s_under, s_halt;
  logic [3:0]  s_code, s_level;
  logic [31:0] s_mpc, s_ret;
  logic [15:0] s_err;
  logic        n_ready, n_mis, n_under, n_halt;
  logic [3:0]  n_code, n_level;
  logic [31:0] n_mpc, n_ret;
  logic [15:0] n_err;

  int checks = 0;
  int errors = 0;
  rec_t recs [13];

  always #5 clk = ~clk;

  commit_checker #(.Depth(8), .StopOnErr(1'b1)) u_stop (
    .clk_i(clk), .reset_ni(reset_n), .clear_i(clear),
    .exp_valid_i(exp_valid), .exp_ready_o(s_ready),
    .exp_pc_i(e.pc), .exp_inst_i(e.inst), .exp_rdv_i(e.rdv), .exp_rd_i(e.rd),
    .exp_rd_data_i(e.rd_data), .exp_pcv_i(e.pcv), .exp_pc_x_i(e.pc_x),
    .ret_valid_i(ret_valid),
    .ret_pc_i(r.pc), .ret_inst_i(r.inst), .ret_rdv_i(r.rdv), .ret_rd_i(r.rd),
    .ret_rd_data_i(r.rd_data), .ret_pcv_i(r.pcv), .ret_pc_x_i(r.pc_x),
    .mismatch_o(s_mis), .mismatch_code_o(s_code), .mismatch_pc_o(s_mpc),
    .underflow_o(s_under), .halted_o(s_halt), .level_o(s_level),
    .retire_count_o(s_ret), .error_count_o(s_err)
  );

  commit_checker #(.Depth(8), .StopOnErr(1'b0)) u_nostop (
    .clk_i(clk), .reset_ni(reset_n), .clear_i(clear),
    .exp_valid_i(exp_valid), .exp_ready_o(n_ready),
    .exp_pc_i(e.pc), .exp_inst_i(e.inst), .exp_rdv_i(e.rdv), .exp_rd_i(e.rd),
    .exp_rd_data_i(e.rd_data), .exp_pcv_i(e.pcv), .exp_pc_x_i(e.pc_x),
    .ret_valid_i(ret_valid),
    .ret_pc_i(r.pc), .ret_inst_i(r.inst), .ret_rdv_i(r.rdv), .ret_rd_i(r.rd),
    .ret_rd_data_i(r.rd_data), .ret_pcv_i(r.pcv), .ret_pc_x_i(r.pc_x),
    .mismatch_o(n_mis), .mismatch_code_o(n_code), .mismatch_pc_o(n_mpc),
    .underflow_o(n_under), .halted_o(n_halt), .level_o(n_level),
    .retire_count_o(n_ret), .error_count_o(n_err)
  );

  function automatic rec_t mk(input logic [31:0] pc, input logic [31:0] inst, input logic rdv,
                              input logic [4:0] rd, input logic [31:0] data, input logic pcv,
                              input logic [31:0] pcx);
    rec_t t;
    t = '{pc: pc, inst: inst, rdv: rdv, rd: rd, rd_data: data, pcv: pcv, pc_x: pcx};
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  task automatic push(input rec_t t);
    e = t; exp_valid = 1'b1;
    @(negedge clk);
    exp_valid = 1'b0;
  endtask

  task automatic retire(input rec_t t);
    r = t; ret_valid = 1'b1;
    @(negedge clk);
    ret_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  initial begin
    rec_t t;
    reset_n = 1'b0; clear = 1'b0; exp_valid = 1'b0; ret_valid = 1'b0;
    e = '0; r = '0;
    repeat (2) @(negedge clk);
    check("rst_level", 32'(s_level), 0);
    check("rst_ready", 32'(s_ready), 1);
    check("rst_halt", 32'(s_halt), 0);
    check("rst_code", 32'(s_code), 0);
    check("rst_retire", s_ret, 0);
    check("rst_err", 32'(s_err), 0);
    reset_n = 1'b1;

    // T1: three exact retirements
    recs[0] = mk(32'h0, 32'h00100093, 1'b1, 5'd1, 32'd1, 1'b0, 32'h0);
    recs[1] = mk(32'h4, 32'h00200113, 1'b1, 5'd2, 32'd2, 1'b0, 32'h0);
    recs[2] = mk(32'h8, 32'h00300193, 1'b1, 5'd3, 32'd3, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) push(recs[i]);
    check("t1_level3", 32'(s_level), 3);
    for (int i = 0; i < 3; i++) begin
      retire(recs[i]);
      check("t1_mis", 32'(s_mis), 0);
      check("t1_level", 32'(s_level), 32'(2 - i));
    end
    check("t1_retire", s_ret, 3);

    // T2: rd data mismatch halts
    t = mk(32'hC, 32'h01000293, 1'b1, 5'd5, 32'h10, 1'b0, 32'h0);
    push(t);
    t.rd_data = 32'h11;
    retire(t);
    check("t2_mis", 32'(s_mis), 1);
    check("t2_code", 32'(s_code), 32'h4);
    check("t2_mpc", s_mpc, 32'hC);
    check("t2_halt", 32'(s_halt), 1);
    check("t2_ready", 32'(s_ready), 0);
    check("t2_err", 32'(s_err), 1);
    @(negedge clk);
    check("t2_pulse", 32'(s_mis), 0);
    check("t2_code_hold", 32'(s_code), 32'h4);
    do_clear();

    // T3: x0 data ignored; missing redirect flagged
    t = mk(32'h10, 32'h00000013, 1'b1, 5'd0, 32'h0, 1'b0, 32'h0);
    push(t);
    t.rd_data = 32'hdead;
    retire(t);
    check("t3_x0_mis", 32'(s_mis), 0);
    t = mk(32'h14, 32'h00000463, 1'b0, 5'd0, 32'h0, 1'b1, 32'h40);
    push(t);
    t.pcv = 1'b0; t.pc_x = 32'h0;
    retire(t);
    check("t3_mis", 32'(s_mis), 1);
    check("t3_code", 32'(s_code), 32'h8);
    check("t3_mpc", s_mpc, 32'h14);
    do_clear();

    // T4: fill, refused push while popping, wrap-around order
    for (int i = 0; i < 13; i++)
      recs[i] = mk(32'h100 + 32'(4 * i), 32'(i), 1'b0, 5'd0, 32'h0, 1'b0, 32'h0);
    for (int i = 0; i < 8; i++) push(recs[i]);
    check("t4_full_level", 32'(s_level), 8);
    check("t4_full_ready", 32'(s_ready), 0);
    e = mk(32'h999, 32'h999, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0);
    exp_valid = 1'b1; r = recs[0]; ret_valid = 1'b1;
    @(negedge clk);
    exp_valid = 1'b0; ret_valid = 1'b0;
    check("t4_refused_level", 32'(s_level), 7);
    check("t4_head_mis", 32'(s_mis), 0);
    for (int i = 1; i < 5; i++) begin
      retire(recs[i]);
      check("t4_order_a", 32'(s_mis), 0);
    end
    check("t4_level3", 32'(s_level), 3);
    for (int i = 8; i < 13; i++) push(recs[i]);
    check("t4_level8", 32'(s_level), 8);
    for (int i = 5; i < 13; i++) begin
      retire(recs[i]);
      check("t4_order_b", 32'(s_mis), 0);
    end
    check("t4_level0", 32'(s_level), 0);
    check("t4_retire", s_ret, 13);
    check("t4_halt", 32'(s_halt), 0);

    // T5: underflow
    do_clear();
    retire(mk(32'h200, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0));
    check("t5_under", 32'(s_under), 1);
    check("t5_code", 32'(s_code), 32'hF);
    check("t5_err", 32'(s_err), 1);
    check("t5_halt", 32'(s_halt), 1);
    check("t5_retire", s_ret, 0);
    do_clear();
    check("t5_clr_level", 32'(s_level), 0);
    check("t5_clr_err", 32'(s_err), 0);
    check("t5_clr_halt", 32'(s_halt), 0);
    check("t5_clr_ready", 32'(s_ready), 1);

    // T6: non-halting instance, four mismatches in eight retirements
    for (int i = 0; i < 8; i++) begin
      recs[i] = mk(32'h300 + 32'(4 * i), 32'h1000 + 32'(i), 1'b1, 5'(i + 1), 32'(i), 1'b0, 0);
      push(recs[i]);
    end
    for (int i = 0; i < 8; i++) begin
      t = recs[i];
      case (i)
        1: t.pc = 32'hbad;
        3: t.inst = 32'hbad;
        5: t.rd_data = 32'hbad;
        6: begin t.pcv = 1'b1; t.pc_x = 32'h40; end
        default: ;
      endcase
      retire(t);
      check("t6_mis", 32'(n_mis), (i == 1 || i == 3 || i == 5 || i == 6) ? 1 : 0);
      if (i == 1) check("t6_code_pc", 32'(n_code), 32'h1);
      if (i == 3) check("t6_code_inst", 32'(n_code), 32'h2);
      if (i == 5) check("t6_code_rd", 32'(n_code), 32'h4);
      if (i == 6) check("t6_code_redir", 32'(n_code), 32'h8);
    end
    check("t6_err", 32'(n_err), 4);
    check("t6_retire", n_ret, 8);
    check("t6_halt", 32'(n_halt), 0);

    // Reset lands on the same cycle as a failing retirement
    push(recs[0]);
    push(recs[1]);
    t = recs[0]; t.pc = 32'hbad;
    r = t; ret_valid = 1'b1; reset_n = 1'b0;
    @(negedge clk);
    ret_valid = 1'b0; reset_n = 1'b1;
    check("t6_rst_mis", 32'(n_mis), 0);
    check("t6_rst_code", 32'(n_code), 0);
    check("t6_rst_mpc", n_mpc, 0);
    check("t6_rst_under", 32'(n_under), 0);
    check("t6_rst_level", 32'(n_level), 0);
    check("t6_rst_ready", 32'(n_ready), 1);
    check("t6_rst_retire", n_ret, 0);
    check("t6_rst_err", 32'(n_err), 0);
    check("t6_rst_halt_s", 32'(s_halt), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
